// File: rtl/disp_pkg.sv
// Shared constants, state type and slot helper for the stopwatch display scan controller.
package disp_pkg;

    localparam int NUM_DIG = 7;
    localparam int IDX_W   = 3;

    localparam logic [IDX_W-1:0] SLOT_MT  = 3'd0;
    localparam logic [IDX_W-1:0] SLOT_MO  = 3'd1;
    localparam logic [IDX_W-1:0] SLOT_ST  = 3'd2;
    localparam logic [IDX_W-1:0] SLOT_SO  = 3'd3;
    localparam logic [IDX_W-1:0] SLOT_MSH = 3'd4;
    localparam logic [IDX_W-1:0] SLOT_MST = 3'd5;
    localparam logic [IDX_W-1:0] SLOT_MSO = 3'd6;

    localparam int         MAX_MIN_SEC = 59;
    localparam int         MAX_MS      = 999;
    localparam logic [3:0] BLANK       = 4'hF;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    function automatic logic [NUM_DIG-1:0] slot_onehot(input logic [IDX_W-1:0] idx);
        return NUM_DIG'(1) << idx;
    endfunction

endpackage

// File: rtl/bin2bcd3.sv
// Combinational binary to three-digit BCD; input expected in 0..999.
module bin2bcd3 (
    input  logic [9:0] bin,
    output logic [3:0] hun,
    output logic [3:0] ten,
    output logic [3:0] one
);

    assign hun = 4'(bin / 10'd100);
    assign ten = 4'((bin % 10'd100) / 10'd10);
    assign one = 4'(bin % 10'd10);

endmodule

// File: rtl/disp_scan_ctrl.sv
// 7-digit MM SS mmm display scanner with per-frame coherent snapshot.
// Optional macro LEAD_ZERO_BLANK_EN blanks the minute-tens digit when it is zero.
//
// state | meaning
// IDLE  | display blank, waiting for first tick to capture and show slot 0
// SCAN  | walking slots 0..6, one per tick; snapshot reloads at frame wrap
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               hold,
    input  logic [7:0]         m,
    input  logic [7:0]         s,
    input  logic [9:0]         ms,
    output logic [3:0]         digit,
    output logic [NUM_DIG-1:0] an,
    output logic               dp,
    output logic               frame_start,
    output logic               range_err
);

    localparam int             CNT_W   = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;
    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [5:0]       snap_m, snap_s, snap_m_nxt, snap_s_nxt;
    logic [9:0]       snap_ms, snap_ms_nxt;

    logic             tick, capture, drive, fs_nxt, err_nxt;
    logic [5:0]       cl_m, cl_s;
    logic [9:0]       cl_ms;
    logic             clamp_any;

    logic [9:0]       ms_sel_val;
    logic [3:0]       sel_hun_unused, sel_ten, sel_one;
    logic [3:0]       ms_hun, ms_ten, ms_one;

    logic [3:0]         dig_nxt;
    logic [NUM_DIG-1:0] an_nxt;
    logic               dp_nxt;

    assign tick = en && (cnt == CNT_MAX);

    assign cl_m      = (m  > 8'(MAX_MIN_SEC)) ? 6'(MAX_MIN_SEC) : m[5:0];
    assign cl_s      = (s  > 8'(MAX_MIN_SEC)) ? 6'(MAX_MIN_SEC) : s[5:0];
    assign cl_ms     = (ms > 10'(MAX_MS))     ? 10'(MAX_MS)     : ms;
    assign clamp_any = (m > 8'(MAX_MIN_SEC)) || (s > 8'(MAX_MIN_SEC)) || (ms > 10'(MAX_MS));

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        capture   = 1'b0;
        drive     = 1'b0;
        fs_nxt    = 1'b0;
        if (tick) begin
            drive = 1'b1;
            case (state)
                IDLE: begin
                    capture   = 1'b1;
                    idx_nxt   = SLOT_MT;
                    fs_nxt    = 1'b1;
                    state_nxt = SCAN;
                end
                SCAN: begin
                    if (idx == SLOT_MSO) begin
                        idx_nxt = SLOT_MT;
                        capture = !hold;
                        fs_nxt  = 1'b1;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Slot 0 of a new frame must show the snapshot being captured on this same edge.
    assign snap_m_nxt  = capture ? cl_m  : snap_m;
    assign snap_s_nxt  = capture ? cl_s  : snap_s;
    assign snap_ms_nxt = capture ? cl_ms : snap_ms;
    assign err_nxt     = capture ? clamp_any : range_err;

    assign ms_sel_val = (idx_nxt == SLOT_MT || idx_nxt == SLOT_MO) ? {4'd0, snap_m_nxt}
                                                                   : {4'd0, snap_s_nxt};

    bin2bcd3 u_bcd_ms_sel (
        .bin (ms_sel_val),
        .hun (sel_hun_unused),
        .ten (sel_ten),
        .one (sel_one)
    );

    bin2bcd3 u_bcd_msec (
        .bin (snap_ms_nxt),
        .hun (ms_hun),
        .ten (ms_ten),
        .one (ms_one)
    );

    always_comb begin
        dig_nxt = BLANK;
        an_nxt  = slot_onehot(idx_nxt);
        dp_nxt  = (idx_nxt == SLOT_MO) || (idx_nxt == SLOT_SO);
        case (idx_nxt)
            SLOT_MT, SLOT_ST: dig_nxt = sel_ten;
            SLOT_MO, SLOT_SO: dig_nxt = sel_one;
            SLOT_MSH:         dig_nxt = ms_hun;
            SLOT_MST:         dig_nxt = ms_ten;
            SLOT_MSO:         dig_nxt = ms_one;
            default:          dig_nxt = BLANK;
        endcase
`ifdef LEAD_ZERO_BLANK_EN
        if (idx_nxt == SLOT_MT && sel_ten == 4'd0) begin
            an_nxt  = '0;
            dig_nxt = BLANK;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            state       <= IDLE;
            idx         <= SLOT_MT;
            snap_m      <= '0;
            snap_s      <= '0;
            snap_ms     <= '0;
            range_err   <= 1'b0;
            frame_start <= 1'b0;
            digit       <= BLANK;
            an          <= '0;
            dp          <= 1'b0;
        end else begin
            if (en) begin
                cnt <= tick ? '0 : cnt + 1'b1;
            end
            state       <= state_nxt;
            idx         <= idx_nxt;
            snap_m      <= snap_m_nxt;
            snap_s      <= snap_s_nxt;
            snap_ms     <= snap_ms_nxt;
            range_err   <= err_nxt;
            frame_start <= fs_nxt;
            if (drive) begin
                digit <= dig_nxt;
                an    <= an_nxt;
                dp    <= dp_nxt;
            end
        end
    end

endmodule
